// File: rtl/bus_timer_slave.sv
// Memory-mapped free-running timer with compare/match interrupt on a req/ack bus.
// Latency: ack in the cycle that begins ACK_DELAY edges after the accept edge; busy lasts ACK_DELAY+1 cycles.
// Backpressure: a request is held until ack; a still-held request parks in HOLD and is never served twice.
module bus_timer_slave #(
  parameter logic [31:0] BASE_ADDR = 32'h0004_0000,
  parameter int unsigned ACK_DELAY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rreq,
  input  logic        wreq,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        busy,
  output logic        ack,
  output logic        irq
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP, HOLD} state_t;

  // Value loaded into the delay counter on accept; unused when ACK_DELAY is 0.
  localparam logic [2:0] DLY_LOAD = (ACK_DELAY > 0) ? 3'(ACK_DELAY - 1) : 3'd0;

  state_t      state, state_nxt;
  logic [2:0]  dly_cnt, dly_nxt;

  logic [1:0]  sel_r;
  logic        wr_r;
  logic [31:0] wdata_r;

  logic [31:0] count_r;
  logic [31:0] compare_r;
  logic        en_r, autoclr_r, ie_r;
  logic        match_r;

  logic        hit;
  logic        bus_wr;
  logic        match_now;
  logic [31:0] rd_mux;
  logic        unused_addr_lsb;

  // Byte lanes are not decoded; only word-aligned register selection matters.
  assign unused_addr_lsb = ^addr[1:0];

  assign hit       = (rreq | wreq) && (addr[31:4] == BASE_ADDR[31:4]);
  assign bus_wr    = (state == RESP) && wr_r;
  assign match_now = en_r && (count_r == compare_r);

  // State and delay counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      dly_cnt <= 3'd0;
    end else begin
      state   <= state_nxt;
      dly_cnt <= dly_nxt;
    end
  end

  // Next-state logic: accept, optional wait, one response cycle, then hold until release.
  always_comb begin
    state_nxt = state;
    dly_nxt   = dly_cnt;
    case (state)
      IDLE: begin
        if (hit) begin
          if (ACK_DELAY > 0) begin
            state_nxt = WAIT;
            dly_nxt   = DLY_LOAD;
          end else begin
            state_nxt = RESP;
          end
        end
      end
      WAIT: begin
        if (dly_cnt == 3'd0) state_nxt = RESP;
        else                 dly_nxt   = dly_cnt - 3'd1;
      end
      RESP:    state_nxt = HOLD;
      HOLD:    if (!rreq && !wreq) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Capture the request on accept so later input changes cannot disturb it; write wins over read.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sel_r   <= 2'd0;
      wr_r    <= 1'b0;
      wdata_r <= 32'd0;
    end else if (state == IDLE && hit) begin
      sel_r   <= addr[3:2];
      wr_r    <= wreq;
      wdata_r <= wdata;
    end
  end

  // Timer registers: bus writes land at the RESP edge and override counting; match set beats clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_r   <= 32'd0;
      compare_r <= 32'd0;
      en_r      <= 1'b0;
      autoclr_r <= 1'b0;
      ie_r      <= 1'b0;
      match_r   <= 1'b0;
    end else begin
      if (bus_wr && sel_r == 2'd0)      count_r <= wdata_r;
      else if (match_now && autoclr_r)  count_r <= 32'd0;
      else if (en_r)                    count_r <= count_r + 32'd1;

      if (bus_wr && sel_r == 2'd1) compare_r <= wdata_r;

      if (bus_wr && sel_r == 2'd2) begin
        en_r      <= wdata_r[0];
        autoclr_r <= wdata_r[1];
        ie_r      <= wdata_r[2];
      end

      if (match_now)                                    match_r <= 1'b1;
      else if (bus_wr && sel_r == 2'd3 && wdata_r[0])   match_r <= 1'b0;
    end
  end

  // Register read mux, driven onto the bus only during the ack cycle.
  always_comb begin
    rd_mux = 32'd0;
    case (sel_r)
      2'd0:    rd_mux = count_r;
      2'd1:    rd_mux = compare_r;
      2'd2:    rd_mux = {29'd0, ie_r, autoclr_r, en_r};
      default: rd_mux = {31'd0, match_r};
    endcase
  end

  assign busy  = (state == WAIT) || (state == RESP);
  assign ack   = (state == RESP);
  assign rdata = ack ? rd_mux : 32'd0;
  assign irq   = match_r && ie_r;

endmodule

// File: doc/bus_timer_slave.md
BUS_TIMER_SLAVE -- requirements
Module: bus_timer_slave

Interface
REQ-001 Parameter BASE_ADDR, default 32'h0004_0000: byte base of the 16-byte register window; bits [3:0] are zero.
REQ-002 Parameter ACK_DELAY, default 1: extra wait cycles between request accept and ack; legal range 0..7.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 rreq  input  1  bus read request; held high by the bus controller until ack.
REQ-006 wreq  input  1  bus write request; held high by the bus controller until ack.
REQ-007 addr  input  32  byte address of the request.
REQ-008 wdata  input  32  write data, valid while wreq is high.
REQ-009 rdata  output  32  read data, valid in the cycle ack is high, 0 otherwise.
REQ-010 busy  output  1  high from request accept through the ack cycle.
REQ-011 ack  output  1  one-cycle completion pulse.
REQ-012 irq  output  1  level interrupt: STATUS.match AND CTRL.ie.

Function
REQ-013 The block is hit when (rreq|wreq) is high and addr[31:4]==BASE_ADDR[31:4]; addr[1:0] are ignored, and addr[3:2] selects the register.
REQ-014 Register map:
- 0x0 COUNT: R/W, 32 bits.
- 0x4 COMPARE: R/W, 32 bits.
- 0x8 CTRL: R/W; bit0 en, bit1 autoclr, bit2 ie; bits[31:3] read 0.
- 0xC STATUS: bit0 match; writing 1 clears it; bits[31:1] read 0.
REQ-015 FSM states: IDLE, WAIT, RESP, HOLD.
REQ-016 IDLE->WAIT on a hit when ACK_DELAY>0, loading the delay counter with ACK_DELAY-1.
REQ-017 IDLE->RESP directly on a hit when ACK_DELAY==0.
REQ-018 WAIT decrements its counter and goes to RESP when the counter equals 0.
REQ-019 RESP always goes to HOLD.
REQ-020 HOLD returns to IDLE when rreq and wreq are both low; otherwise it stays in HOLD, so a held request never triggers a second access.
REQ-021 addr, wdata and the read/write kind are latched on accept; later changes to the inputs do not affect the transaction.
REQ-022 busy is high in WAIT and RESP; ack is high only in RESP.
REQ-023 Hit-to-ack latency is ACK_DELAY+1 cycles after the accept edge.
REQ-024 A write takes effect at the RESP edge.
REQ-025 Read data is sampled from the register state at the RESP cycle and is driven on rdata only while ack is high.
REQ-026 If rreq and wreq are both high on accept, the access is a write.
REQ-027 A miss (address outside the window) produces no busy and no ack, and the state stays IDLE.
REQ-028 Counter: when en==1, COUNT increments by 1 each cycle and wraps from 32'hFFFF_FFFF to 0 without a flag.
REQ-029 Match: when en==1 and COUNT==COMPARE at an edge, match is set the next cycle.
REQ-030 Match with autoclr==1: COUNT loads 0 instead of COUNT+1 on the matching edge.
REQ-031 A bus write to COUNT in the same cycle as an increment or autoclear: the written value wins.
REQ-032 A STATUS write-1-clear in the same cycle as a new match: set wins.
REQ-033 Writing COMPARE does not retroactively set match; evaluation uses the register values of the current cycle.
REQ-034 irq is combinational from registered bits, with no added latency.

Reset
REQ-035 When reset is asserted, FSM=IDLE; COUNT, COMPARE, CTRL and STATUS are 0; delay counter is 0; rdata, busy, ack and irq are 0.
REQ-036 Reset mid-transaction abandons the access with no register update, and no ack is ever issued for it.
REQ-037 After reset deasserts, a still-high request is treated as a new hit from IDLE.

Verification
REQ-038 Write-read, ACK_DELAY=1: wreq to 0x0004_0004 with 32'h0000_0010, then rreq to the same address -> busy for 2 cycles each, ack once each, rdata=32'h0000_0010.
REQ-039 Count and match: COMPARE=5, CTRL=32'h5 (en, ie), autoclr=0 -> match and irq high the cycle after COUNT==5, COUNT continues 6, 7, ...; write 32'h1 to 0x...C -> irq low.
REQ-040 Autoclear: COMPARE=3, CTRL=32'h3 -> COUNT sequence 0, 1, 2, 3, 0, 1, ... and match stays set.
REQ-041 Collision: en=1 and a COUNT write of 32'hFFFF_FFF0 landing on an increment edge -> COUNT=32'hFFFF_FFF0 then 32'hFFFF_FFF1.
REQ-042 Protocol: rreq held 10 cycles at 0x0004_0000 -> exactly one ack.
REQ-043 Miss: rreq to 0x0004_0010 -> busy and ack stay 0 throughout.
REQ-044 Reset: reset asserted in WAIT -> outputs 0 immediately, registers 0, and no ack is issued for the abandoned access.
